mips_data_mem: RTL



---
 rtl/mips_mem_pkg.sv | 17 +
 rtl/mips_data_mem.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data memory: access-sequencer states, big-endian
// byte-lane bundle and the word-index width helper.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT
    } mem_state_t;

    typedef logic [7:0] byte_lanes_t [4];

    function automatic int word_idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mips_data_mem.sv
// Word-wide data memory with fixed access latency and a zeroing sweep after reset.
// Define MEM_ALIGN_CHECK_EN to add the mem_err port and reject misaligned accesses.
module mips_data_mem
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic        mem_write_en,
    input  byte_lanes_t mem_data_in,
    output byte_lanes_t mem_data_out,
    output logic        mem_ready,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        mem_err,
`endif
    output logic        mem_busy
);

    localparam int AW = word_idx_width(MEM_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    mem_state_t    state_q, state_d;
    logic [AW-1:0] clr_q, clr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          mis_q, mis_d;
    logic [31:0]   dout_q, dout_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
`ifdef MEM_ALIGN_CHECK_EN
    logic          err_q, err_d;
`endif

    logic [31:0]   mem_q [MEM_WORDS];

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_word;
    logic          acc_go;
    logic          acc_we;
    logic          acc_mis;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_word;
    logic [31:0]   req_word;
    logic          req_mis;
    logic          unused_addr;

    // Lane 0 is the most significant byte (big-endian).
    assign req_word = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};

`ifdef MEM_ALIGN_CHECK_EN
    assign req_mis = |mem_addr[1:0];
`else
    assign req_mis = 1'b0;
`endif

    assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    always_comb begin
        state_d  = state_q;
        clr_d    = clr_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        mis_d    = mis_q;
        dout_d   = dout_q;
        ready_d  = 1'b0;
        acc_go   = 1'b0;
        acc_we   = we_q;
        acc_mis  = mis_q;
        acc_idx  = idx_q;
        acc_word = wdata_q;
        wr_en    = 1'b0;
        wr_idx   = clr_q;
        wr_word  = '0;

        case (state_q)
            CLEAR: begin
                wr_en = 1'b1;
                clr_d = clr_q + 1'b1;
                if (clr_q == AW'(MEM_WORDS - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (mem_req) begin
                    idx_d   = mem_addr[AW+1:2];
                    we_d    = mem_write_en;
                    wdata_d = req_word;
                    mis_d   = req_mis;
                    // Single-cycle latency completes straight from the port values.
                    if (LATENCY == 1) begin
                        acc_go   = 1'b1;
                        acc_we   = mem_write_en;
                        acc_mis  = req_mis;
                        acc_idx  = mem_addr[AW+1:2];
                        acc_word = req_word;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    acc_go  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase

        if (acc_go) begin
            ready_d = 1'b1;
            if (acc_we) begin
                if (!acc_mis) begin
                    wr_en   = 1'b1;
                    wr_idx  = acc_idx;
                    wr_word = acc_word;
                end
            end else begin
                dout_d = acc_mis ? '0 : mem_q[acc_idx];
            end
        end

        busy_d = (state_d == CLEAR);
`ifdef MEM_ALIGN_CHECK_EN
        err_d = acc_go && acc_mis;
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= CLEAR;
            clr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef MEM_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // The array has no reset; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    assign mem_data_out[0] = dout_q[31:24];
    assign mem_data_out[1] = dout_q[23:16];
    assign mem_data_out[2] = dout_q[15:8];
    assign mem_data_out[3] = dout_q[7:0];
    assign mem_ready       = ready_q;
    assign mem_busy        = busy_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign mem_err         = err_q;
`endif

endmodule
